voice_allocator: RTL
====================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of envelope/voice channels driven (2..16).
REQ-002 Parameter NOTE_BITS, default 7, note number width.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 note_valid  input  1  note event present.
REQ-006 note_ready  output  1  allocator can accept an event.
REQ-007 note_on  input  1  1 = note-on, 0 = note-off.
REQ-008 note_num  input  NOTE_BITS  note number of the event.
REQ-009 note_vel  input  32  velocity word; [31:16] attack level, [15:0] decay level.
REQ-010 voice_avail  input  NUM_VOICES  one-cycle pulse per voice when its envelope has returned to idle.
REQ-011 voice_en  output  NUM_VOICES  gate per voice; high = key held.
REQ-012 voice_note  output  NUM_VOICES*NOTE_BITS  note assigned to each voice, voice k at [k*NOTE_BITS +: NOTE_BITS].
REQ-013 voice_velocity  output  NUM_VOICES*32  velocity per voice, voice k at [k*32 +: 32].
REQ-014 drop_count  output  8  saturating count of note-on events dropped for lack of a voice.

Function
REQ-015 Each voice holds state FREE, HELD or RELEASING; voice_en[k] = 1 exactly when voice k is HELD.
REQ-016 Control FSM states S_IDLE and S_APPLY; note_ready = 1 only in S_IDLE.
REQ-017 S_IDLE: note_valid & note_ready latches note_on/note_num/note_vel, moves to S_APPLY; note_ready low the next cycle.
REQ-018 S_APPLY: event applied to voice state in one cycle, return to S_IDLE; max throughput one event per 2 cycles.
REQ-019 Note-on, match: HELD voice with same note exists -> event ignored, no state change, no drop.
REQ-020 Note-on, retrigger: else lowest-index RELEASING voice with same note -> that voice becomes HELD, velocity updated.
REQ-021 Note-on, allocate: else lowest-index FREE voice -> becomes HELD; voice_note and voice_velocity loaded in that cycle.
REQ-022 Note-on, none free: no state change; drop_count increments, saturating at 255.
REQ-023 Note-off: every HELD voice with matching note -> RELEASING; voice_note/voice_velocity retained; no match -> ignored.
REQ-024 voice_avail[k] while voice k RELEASING -> FREE next edge; while FREE or HELD -> ignored.
REQ-025 Same-cycle voice_avail[k] and S_APPLY: avail applied first; a voice freed this cycle is eligible for allocation in the same S_APPLY.
REQ-026 Same-cycle voice_avail[k] and retrigger of voice k: retrigger wins; voice k ends HELD.
REQ-027 Outputs are registered; voice_en changes exactly one cycle after the S_APPLY cycle decides it (2 cycles after acceptance).
REQ-028 Inputs sampled only on acceptance; note_* changes while note_ready = 0 have no effect.

Reset
REQ-029 rst high clears asynchronously: all voices FREE, voice_en = 0, voice_note = 0, voice_velocity = 0, drop_count = 0, FSM S_IDLE.
REQ-030 note_ready = 0 while rst high, 1 on the first edge after release.
REQ-031 Reset mid-event discards the latched event; no voice changes after reset release.

Verification
REQ-032 Reset release, note-on 60 vel 0x80004000 -> voice_en = 0001 two cycles after acceptance, voice_note[0] = 60, voice_velocity[0] = 0x80004000.
REQ-033 Note-on 60,62,64,65,67 back-to-back (NUM_VOICES=4) -> voice_en = 1111, notes 60/62/64/65, drop_count = 1, note_ready toggles 1,0 per event.
REQ-034 Note-off 62 -> voice_en[1] = 0; note-on 62 before avail -> voice 1 HELD again, no new voice used.
REQ-035 Note-off 60, then voice_avail[0] pulse, then note-on 70 -> voice 0 reassigned to 70.
REQ-036 voice_avail[2] pulse in the same cycle as S_APPLY of note-on 71 with voices 0,1,3 HELD, voice 2 RELEASING -> voice 2 HELD with note 71, drop_count unchanged.
REQ-037 rst asserted during S_APPLY of a note-on -> all outputs zero immediately, no voice HELD after release; 260 dropped note-ons -> drop_count = 255.

Source files
------------

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - note-event voice allocator for a polyphonic envelope bank
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_BITS  = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            note_valid,
  output logic                            note_ready,
  input  logic                            note_on,
  input  logic [NOTE_BITS-1:0]            note_num,
  input  logic [31:0]                     note_vel,
  input  logic [NUM_VOICES-1:0]           voice_avail,
  output logic [NUM_VOICES-1:0]           voice_en,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic [NUM_VOICES*32-1:0]        voice_velocity,
  output logic [7:0]                      drop_count
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } ctrl_state_e;

  typedef enum logic [1:0] {
    V_FREE      = 2'd0,
    V_HELD      = 2'd1,
    V_RELEASING = 2'd2
  } voice_state_e;

  ctrl_state_e                     ctrl_q, ctrl_d;
  logic                            ready_q, ready_d;
  logic                            accept;

  logic                            ev_on_q;
  logic [NOTE_BITS-1:0]            ev_num_q;
  logic [31:0]                     ev_vel_q;

  voice_state_e                    vstate_q   [NUM_VOICES];
  voice_state_e                    vstate_d   [NUM_VOICES];
  voice_state_e                    vstate_mid [NUM_VOICES];
  logic [NUM_VOICES*NOTE_BITS-1:0] vnote_q, vnote_d;
  logic [NUM_VOICES*32-1:0]        vvel_q, vvel_d;
  logic [NUM_VOICES-1:0]           en_q, en_d;
  logic [7:0]                      drop_q, drop_d;

  logic                            apply_on, apply_off;
  logic [NUM_VOICES-1:0]           note_hit, held_hit, retrig_sel, free_sel;
  logic                            held_any, retrig_any, free_any;

  // Control FSM next state: accept one event in S_IDLE, spend one cycle applying it
  always_comb begin
    ctrl_d = ctrl_q;
    accept = 1'b0;
    case (ctrl_q)
      S_IDLE: begin
        if (note_valid && ready_q) begin
          accept = 1'b1;
          ctrl_d = S_APPLY;
        end
      end
      S_APPLY: ctrl_d = S_IDLE;
      default: ctrl_d = S_IDLE;
    endcase
    ready_d = (ctrl_d == S_IDLE);
  end

  // Control FSM state and registered ready (held low through reset)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      ready_q <= ready_d;
    end
  end

  // Event latch: note inputs only matter on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_on_q  <= 1'b0;
      ev_num_q <= '0;
      ev_vel_q <= '0;
    end else if (accept) begin
      ev_on_q  <= note_on;
      ev_num_q <= note_num;
      ev_vel_q <= note_vel;
    end
  end

  // Match and priority decode; avail is folded in before choosing a free voice,
  // but retrigger looks at the pre-avail state so it beats a same-cycle release
  always_comb begin
    apply_on   = (ctrl_q == S_APPLY) && ev_on_q;
    apply_off  = (ctrl_q == S_APPLY) && !ev_on_q;
    note_hit   = '0;
    held_hit   = '0;
    retrig_sel = '0;
    free_sel   = '0;
    retrig_any = 1'b0;
    free_any   = 1'b0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      vstate_mid[k] = (voice_avail[k] && (vstate_q[k] == V_RELEASING)) ? V_FREE : vstate_q[k];
      note_hit[k]   = (vnote_q[k*NOTE_BITS +: NOTE_BITS] == ev_num_q);
      held_hit[k]   = note_hit[k] && (vstate_q[k] == V_HELD);
      if (!retrig_any && note_hit[k] && (vstate_q[k] == V_RELEASING)) begin
        retrig_sel[k] = 1'b1;
        retrig_any    = 1'b1;
      end
      if (!free_any && (vstate_mid[k] == V_FREE)) begin
        free_sel[k] = 1'b1;
        free_any    = 1'b1;
      end
    end
    held_any = |held_hit;
  end

  // Next voice state: apply the latched event on top of the avail-updated state
  always_comb begin
    vstate_d = vstate_mid;
    vnote_d  = vnote_q;
    vvel_d   = vvel_q;
    drop_d   = drop_q;
    en_d     = '0;
    if (apply_on && !held_any) begin
      if (retrig_any) begin
        for (int k = 0; k < NUM_VOICES; k++) begin
          if (retrig_sel[k]) begin
            vstate_d[k]          = V_HELD;
            vvel_d[k*32 +: 32]   = ev_vel_q;
          end
        end
      end else if (free_any) begin
        for (int k = 0; k < NUM_VOICES; k++) begin
          if (free_sel[k]) begin
            vstate_d[k]                        = V_HELD;
            vnote_d[k*NOTE_BITS +: NOTE_BITS]  = ev_num_q;
            vvel_d[k*32 +: 32]                 = ev_vel_q;
          end
        end
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
    if (apply_off) begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        if (held_hit[k]) begin
          vstate_d[k] = V_RELEASING;
        end
      end
    end
    for (int k = 0; k < NUM_VOICES; k++) begin
      en_d[k] = (vstate_d[k] == V_HELD);
    end
  end

  // Voice bank registers; gates are registered alongside the state they mirror
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        vstate_q[k] <= V_FREE;
      end
      vnote_q <= '0;
      vvel_q  <= '0;
      en_q    <= '0;
      drop_q  <= '0;
    end else begin
      vstate_q <= vstate_d;
      vnote_q  <= vnote_d;
      vvel_q   <= vvel_d;
      en_q     <= en_d;
      drop_q   <= drop_d;
    end
  end

  assign note_ready     = ready_q;
  assign voice_en       = en_q;
  assign voice_note     = vnote_q;
  assign voice_velocity = vvel_q;
  assign drop_count     = drop_q;

endmodule
